rsvp_collector: RTL and testbench

- Upstream stage of the outing-decision logic; gathers per-member RSVPs from two hiking-club and two basketball-team members over a valid/ready interface.
- Closes the window when all four have answered or a timeout expires.
- Presents stable 2-bit hikingClub/basketBallTeam attendance vectors plus a held snapshot_valid for the downstream going-out evaluator.

---
 rtl/rsvp_collector.sv | 127 ++++++++++++
 tb/tb_rsvp_collector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsvp_collector.sv
// rsvp_collector: gathers RSVPs from two hiking-club and two basketball members
// over valid/ready, closes on all-answered or timeout, then holds a snapshot
// until the consumer acknowledges it.
// Optional build macro DECLINE_LOCK_EN: the first answer per member is final.
// Without it, a repeated answer for the same member overwrites the earlier one.
module rsvp_collector #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       start,
    input  logic       rsvp_valid,
    output logic       rsvp_ready,
    input  logic       rsvp_team,
    input  logic       rsvp_member,
    input  logic       rsvp_yes,
    output logic [1:0] hikingClub,
    output logic [1:0] basketBallTeam,
    output logic       snapshot_valid,
    input  logic       snapshot_ack,
    output logic       timed_out,
    output logic [3:0] responded
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    typedef struct packed {
        logic team;
        logic member;
        logic yes;
    } rsvp_beat_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nxt;
    rsvp_beat_t beat;
    logic [1:0] idx;
    logic [3:0] acc, acc_nxt, resp_nxt;
    logic [CNT_W-1:0] timer;
    logic       accept, complete, close, close_to;

    assign beat = '{team: rsvp_team, member: rsvp_member, yes: rsvp_yes};
    assign idx  = {beat.team, beat.member};

    // Next accumulator/responded values if the current beat is taken.
    always_comb begin
        accept   = (state == COLLECT) && rsvp_valid;
        acc_nxt  = acc;
        resp_nxt = responded;
        if (accept) begin
            resp_nxt[idx] = 1'b1;
`ifdef DECLINE_LOCK_EN
            if (!responded[idx])
                acc_nxt[idx] = beat.yes;
`else
            acc_nxt[idx] = beat.yes;
`endif
        end
        complete = accept && (resp_nxt == 4'hF);
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; completion takes priority over timeout.
    always_comb begin
        state_nxt      = state;
        rsvp_ready     = 1'b0;
        snapshot_valid = 1'b0;
        close          = 1'b0;
        close_to       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                rsvp_ready = 1'b1;
                if (complete) begin
                    state_nxt = DONE;
                    close     = 1'b1;
                end else if (timer == LAST_CNT) begin
                    state_nxt = DONE;
                    close     = 1'b1;
                    close_to  = 1'b1;
                end
            end
            DONE: begin
                snapshot_valid = 1'b1;
                if (snapshot_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window datapath: accumulators, responded map, timer, and snapshot load on close.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc            <= '0;
            responded      <= '0;
            timer          <= '0;
            timed_out      <= 1'b0;
            hikingClub     <= '0;
            basketBallTeam <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                acc       <= '0;
                responded <= '0;
                timer     <= '0;
                timed_out <= 1'b0;
            end
        end else if (state == COLLECT) begin
            acc       <= acc_nxt;
            responded <= resp_nxt;
            timer     <= timer + 1'b1;
            if (close) begin
                hikingClub     <= acc_nxt[1:0];
                basketBallTeam <= acc_nxt[3:2];
                timed_out      <= close_to;
            end
        end
    end

endmodule

// File: tb/tb_rsvp_collector.sv
// Scoreboard bench for rsvp_collector: stimulus pushes expected snapshots,
// a negedge monitor pops and compares on each rising snapshot_valid.
module tb_rsvp_collector;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic       start = 1'b0;
    logic       rsvp_valid = 1'b0;
    logic       rsvp_ready;
    logic       rsvp_team = 1'b0;
    logic       rsvp_member = 1'b0;
    logic       rsvp_yes = 1'b0;
    logic [1:0] hikingClub;
    logic [1:0] basketBallTeam;
    logic       snapshot_valid;
    logic       snapshot_ack = 1'b0;
    logic       timed_out;
    logic [3:0] responded;

    rsvp_collector #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start),
        .rsvp_valid(rsvp_valid), .rsvp_ready(rsvp_ready),
        .rsvp_team(rsvp_team), .rsvp_member(rsvp_member), .rsvp_yes(rsvp_yes),
        .hikingClub(hikingClub), .basketBallTeam(basketBallTeam),
        .snapshot_valid(snapshot_valid), .snapshot_ack(snapshot_ack),
        .timed_out(timed_out), .responded(responded)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] hc;
        logic [1:0] bb;
        logic       to;
        logic [3:0] resp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    logic sv_prev = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic expect_snap(input logic [1:0] hc, input logic [1:0] bb,
                               input logic to, input logic [3:0] resp);
        exp_t x;
        x.hc = hc; x.bb = bb; x.to = to; x.resp = resp;
        q.push_back(x);
    endtask

    // Monitor: compare each new snapshot against the oldest expectation.
    always @(negedge Clk) begin
        if (snapshot_valid && !sv_prev) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_snapshot actual=1 expected=0");
            end else begin
                e = q.pop_front();
                chk("snap_hiking", {6'd0, hikingClub}, {6'd0, e.hc});
                chk("snap_basket", {6'd0, basketBallTeam}, {6'd0, e.bb});
                chk("snap_timed_out", {7'd0, timed_out}, {7'd0, e.to});
                chk("snap_responded", {4'd0, responded}, {4'd0, e.resp});
            end
        end
        sv_prev <= snapshot_valid;
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic t, input logic m, input logic y);
        rsvp_valid = 1'b1; rsvp_team = t; rsvp_member = m; rsvp_yes = y;
        tick();
        rsvp_valid = 1'b0;
    endtask

    task automatic do_ack();
        snapshot_ack = 1'b1;
        tick();
        snapshot_ack = 1'b0;
        chk("ack_sv_low", {7'd0, snapshot_valid}, 8'd0);
        chk("ack_ready_low", {7'd0, rsvp_ready}, 8'd0);
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !snapshot_valid; i++) tick();
        chk("wait_done", {7'd0, snapshot_valid}, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit actual=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        #3 Rst_n = 1'b0;
        #2;
        chk("rst_ready", {7'd0, rsvp_ready}, 8'd0);
        chk("rst_sv", {7'd0, snapshot_valid}, 8'd0);
        chk("rst_hiking", {6'd0, hikingClub}, 8'd0);
        chk("rst_basket", {6'd0, basketBallTeam}, 8'd0);
        chk("rst_to", {7'd0, timed_out}, 8'd0);
        chk("rst_resp", {4'd0, responded}, 8'd0);
        tick(); tick();
        Rst_n = 1'b1;
        tick();

        // T1: four back-to-back yes beats
        do_start();
        chk("t1_ready", {7'd0, rsvp_ready}, 8'd1);
        beat(0, 0, 1); beat(0, 1, 1); beat(1, 0, 1);
        chk("t1_sv_before", {7'd0, snapshot_valid}, 8'd0);
        expect_snap(2'b11, 2'b11, 1'b0, 4'hF);
        beat(1, 1, 1);
        chk("t1_latency", {7'd0, snapshot_valid}, 8'd1);
        chk("t1_ready_done", {7'd0, rsvp_ready}, 8'd0);
        do_ack();

        // T2: single h1 yes on cycle 3, timeout after 16 collect cycles
        do_start();
        chk("t2_resp_clear", {4'd0, responded}, 8'd0);
        tick(); tick();
        beat(0, 1, 1);
        repeat (12) tick();
        chk("t2_not_early", {7'd0, snapshot_valid}, 8'd0);
        expect_snap(2'b10, 2'b00, 1'b1, 4'b0010);
        tick();
        chk("t2_exact_window", {7'd0, snapshot_valid}, 8'd1);
        do_ack();

        // T3: duplicate h0 answer
        do_start();
        chk("t3_to_clear", {7'd0, timed_out}, 8'd0);
`ifdef DECLINE_LOCK_EN
        expect_snap(2'b11, 2'b11, 1'b0, 4'hF);
`else
        expect_snap(2'b10, 2'b11, 1'b0, 4'hF);
`endif
        beat(0, 0, 1); beat(0, 0, 0);
        chk("t3_ready_dup", {7'd0, rsvp_ready}, 8'd1);
        beat(0, 1, 1); beat(1, 0, 1); beat(1, 1, 1);
        chk("t3_done", {7'd0, snapshot_valid}, 8'd1);
        do_ack();

        // T4: completing beat lands exactly on the last timer edge
        do_start();
        beat(0, 0, 1); beat(0, 1, 1); beat(1, 0, 1);
        repeat (12) tick();
        chk("t4_not_early", {7'd0, snapshot_valid}, 8'd0);
        chk("t4_resp_partial", {4'd0, responded}, 8'h07);
        expect_snap(2'b11, 2'b11, 1'b0, 4'hF);
        beat(1, 1, 1);
        chk("t4_done", {7'd0, snapshot_valid}, 8'd1);
        do_ack();

        // T5: reset mid-collect with an in-flight beat
        do_start();
        beat(0, 0, 1); beat(1, 1, 1);
        rsvp_valid = 1'b1; rsvp_team = 0; rsvp_member = 1; rsvp_yes = 1;
        #2 Rst_n = 1'b0;
        #1;
        chk("t5_async_ready", {7'd0, rsvp_ready}, 8'd0);
        chk("t5_async_hiking", {6'd0, hikingClub}, 8'd0);
        chk("t5_async_basket", {6'd0, basketBallTeam}, 8'd0);
        chk("t5_async_resp", {4'd0, responded}, 8'd0);
        tick();
        chk("t5_inflight_dropped", {4'd0, responded}, 8'd0);
        rsvp_valid = 1'b0;
        Rst_n = 1'b1;
        tick();
        do_start();
        chk("t5_clean_resp", {4'd0, responded}, 8'd0);
        expect_snap(2'b10, 2'b11, 1'b1, 4'b1110);
        beat(0, 1, 1); beat(1, 0, 1); beat(1, 1, 1);
        wait_done(20);

        // T6: DONE ignores start while unacknowledged
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_hold_sv", {7'd0, snapshot_valid}, 8'd1);
            chk("t6_hold_hiking", {6'd0, hikingClub}, 8'h2);
            chk("t6_hold_basket", {6'd0, basketBallTeam}, 8'h3);
        end
        start = 1'b0;
        do_ack();
        do_start();
        expect_snap(2'b00, 2'b01, 1'b1, 4'b0100);
        beat(1, 0, 1);
        tick(); tick();
        chk("t6_old_hiking", {6'd0, hikingClub}, 8'h2);
        chk("t6_old_basket", {6'd0, basketBallTeam}, 8'h3);
        wait_done(20);
        do_ack();

        tick(); tick();
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
